// File: rtl/spm_seq.sv
// Serial-parallel multiplier: x in parallel, y bit-serial LSB first, 2*SIZE-bit product.
// Optional macro SPM_SERIAL_OUT_EN adds the per-step product bit outputs p / p_vld.
module spm_seq #(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   x,
  input  logic [SIZE-1:0]   y,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef SPM_SERIAL_OUT_EN
  output logic              p,
  output logic              p_vld,
`endif
  output logic [2*SIZE-1:0] prod
);

  localparam int CNT_W = $clog2(2 * SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [SIZE-1:0]  x_r;
  logic [SIZE-1:0]  y_sr;
  logic [SIZE-1:0]  s_r;
  logic [SIZE-1:0]  c_r;
  logic [CNT_W-1:0] cnt;

  logic [SIZE-1:0] pp;
  logic [SIZE-1:0] s_hi;
  logic [SIZE-1:0] s_nxt;
  logic [SIZE-1:0] c_nxt;
  logic            accept;
  logic            run;

  assign accept = (state == IDLE) && in_valid;
  assign run    = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Every cell is a full adder; cell i takes the sum of cell i+1, so the
  // accumulated value shifts right by one each step while s_0 falls out.
  always_comb begin
    pp    = x_r & {SIZE{y_sr[0]}};
    s_hi  = {1'b0, s_r[SIZE-1:1]};
    s_nxt = pp ^ s_hi ^ c_r;
    c_nxt = (pp & s_hi) | (pp & c_r) | (s_hi & c_r);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r  <= '0;
      y_sr <= '0;
      s_r  <= '0;
      c_r  <= '0;
      cnt  <= '0;
      prod <= '0;
    end else if (accept) begin
      x_r  <= x;
      y_sr <= y;
      s_r  <= '0;
      c_r  <= '0;
      cnt  <= '0;
      prod <= '0;
    end else if (run) begin
      s_r  <= s_nxt;
      c_r  <= c_nxt;
      y_sr <= y_sr >> 1;
      cnt  <= cnt + 1'b1;
      prod <= {s_nxt[0], prod[2*SIZE-1:1]};
    end
  end

`ifdef SPM_SERIAL_OUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p     <= 1'b0;
      p_vld <= 1'b0;
    end else begin
      p     <= run ? s_nxt[0] : 1'b0;
      p_vld <= run;
    end
  end
`endif

endmodule

// File: tb/tb_spm_seq.sv
// Self-checking bench for spm_seq (SIZE=8): directed cases plus random operands,
// checked against x*y and the 2*SIZE-cycle latency; also checks p/p_vld when enabled.
module tb_spm_seq;

  localparam int SIZE = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [SIZE-1:0]   x;
  logic [SIZE-1:0]   y;
  logic              out_valid;
  logic              out_ready;
  logic [2*SIZE-1:0] prod;
`ifdef SPM_SERIAL_OUT_EN
  logic              p;
  logic              p_vld;
`endif

  int checks = 0;
  int errors = 0;

  spm_seq #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SPM_SERIAL_OUT_EN
    .p         (p),
    .p_vld     (p_vld),
`endif
    .prod      (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: quiet inputs; 1: random in_valid/out_ready/x/y; 2: random x/y, in_valid held
  task automatic wait_done(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input int mode);
    int early;
    int vld_cnt;
    logic [2*SIZE-1:0] ser;
    logic [2*SIZE-1:0] expect_prod;
    early = 0;
    vld_cnt = 0;
    ser = '0;
    expect_prod = (2*SIZE)'(32'(a) * 32'(b));
    for (int k = 0; k < 2 * SIZE; k++) begin
      if (mode != 0) begin
        x = SIZE'($urandom);
        y = SIZE'($urandom);
      end
      if (mode == 1) begin
        in_valid  = 1'($urandom);
        out_ready = 1'($urandom);
      end
      tick();
      if (k < 2 * SIZE - 1 && (out_valid !== 1'b0 || in_ready !== 1'b0)) early++;
`ifdef SPM_SERIAL_OUT_EN
      if (p_vld === 1'b1) begin
        vld_cnt++;
        ser[k] = p;
      end
`endif
    end
    check_output("early_done", 32'(early), 32'd0);
    check_output("latency_out_valid", 32'(out_valid), 32'd1);
    check_output($sformatf("prod_%02h_x_%02h", a, b), 32'(prod), 32'(expect_prod));
`ifdef SPM_SERIAL_OUT_EN
    check_output("p_vld_count", 32'(vld_cnt), 32'(2 * SIZE));
    check_output("p_serial", 32'(ser), 32'(expect_prod));
`else
    if (vld_cnt != 0 || ser != '0) check_output("serial_off", 32'(vld_cnt), 32'd0);
`endif
  endtask

  task automatic finish_op(input int hold, input bit keep_valid);
    int unstable;
    logic [2*SIZE-1:0] saved;
    unstable = 0;
    saved = prod;
    if (!keep_valid) in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (out_valid !== 1'b1 || prod !== saved) unstable++;
    end
    if (hold > 0) check_output("done_hold_stable", 32'(unstable), 32'd0);
`ifdef SPM_SERIAL_OUT_EN
    if (hold > 0) check_output("p_vld_low_in_done", 32'(p_vld), 32'd0);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("handshake_in_ready", 32'(in_ready), 32'd1);
    check_output("handshake_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic apply_stimulus(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                input int hold, input int mode);
    in_valid = 1'b1;
    x = a;
    y = b;
    tick();
    in_valid = 1'b0;
    check_output("accept_in_ready", 32'(in_ready), 32'd0);
    wait_done(a, b, mode);
    finish_op(hold, 1'b0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    #3;
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_prod", 32'(prod), 32'd0);
`ifdef SPM_SERIAL_OUT_EN
    check_output("reset_p", 32'(p), 32'd0);
    check_output("reset_p_vld", 32'(p_vld), 32'd0);
`endif
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] directed operands");
    apply_stimulus(8'hFF, 8'hFF, 0, 0);
    apply_stimulus(8'h03, 8'h05, 1, 0);
    apply_stimulus(8'h00, 8'hA5, 0, 0);
    apply_stimulus(8'h5A, 8'h00, 0, 1);
    apply_stimulus(8'h01, 8'h80, 10, 1);

    $display("[TB] back-to-back with in_valid held");
    in_valid = 1'b1;
    x = 8'h12;
    y = 8'h34;
    tick();
    check_output("b2b_first_accept", 32'(in_ready), 32'd0);
    wait_done(8'h12, 8'h34, 2);
    x = 8'h80;
    y = 8'h02;
    finish_op(0, 1'b1);
    tick();
    check_output("b2b_second_accept", 32'(in_ready), 32'd0);
    wait_done(8'h80, 8'h02, 2);
    finish_op(0, 1'b0);

    $display("[TB] reset during run");
    in_valid = 1'b1;
    x = 8'h5A;
    y = 8'hC3;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check_output("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check_output("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    check_output("midrun_rst_prod", 32'(prod), 32'd0);
`ifdef SPM_SERIAL_OUT_EN
    check_output("midrun_rst_p_vld", 32'(p_vld), 32'd0);
`endif
    #1;
    rst = 1'b1;
    tick();
    check_output("post_rst_idle", 32'(in_ready), 32'd1);
    apply_stimulus(8'h0F, 8'h0F, 2, 0);

    $display("[TB] random operands");
    for (int n = 0; n < 12; n++) begin
      apply_stimulus(SIZE'($urandom), SIZE'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spm_seq.md
SPM_SEQ -- requirements
Module: spm_seq

Interface
REQ-001 SHALL provide parameter SIZE, default 32: operand width in bits; legal range 2..64.
REQ-002 SHALL provide port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL provide port rst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL provide port in_valid, input, 1: operand pair x/y offered.
REQ-005 SHALL provide port in_ready, output, 1: block accepts an operand pair.
REQ-006 SHALL provide port x, input, SIZE: parallel multiplicand, unsigned.
REQ-007 SHALL provide port y, input, SIZE: multiplier, unsigned, serialised internally LSB first.
REQ-008 SHALL provide port out_valid, output, 1: prod holds a finished product.
REQ-009 SHALL provide port out_ready, input, 1: consumer takes prod.
REQ-010 SHALL provide port prod, output, 2*SIZE: unsigned product x*y.

Function
REQ-011 SHALL implement a FSM with states IDLE, RUN and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-012 SHALL, in IDLE with in_valid=1 (the accept edge): latch x into x_r and y into shift register y_sr, clear all cell registers, clear step counter cnt, clear prod shift register, and enter RUN.
REQ-013 SHALL contain a chain of SIZE carry-save cells i=0..SIZE-1, each holding a sum bit s_i and a carry bit c_i.
REQ-014 SHALL, on each RUN cycle with ybit=y_sr[0], update every cell i as: {c_i, s_i} <= (x_r[i] & ybit) + s_(i+1) + c_i, where s_SIZE is constant 0 and all right-hand values are pre-edge values.
REQ-015 SHALL, on each RUN cycle, shift y_sr right with zero fill, so ybit=0 for steps SIZE..2*SIZE-1.
REQ-016 SHALL, on each RUN cycle, treat the new s_0 value as product bit cnt and shift it into the MSB of the 2*SIZE-bit prod register (right shift), so that bit 0 is LSB after the final step.
REQ-017 SHALL run exactly 2*SIZE RUN cycles (cnt 0..2*SIZE-1), a counter of ceil(log2(2*SIZE)) bits, and on the edge with cnt=2*SIZE-1 enter DONE.
REQ-018 SHALL give latency: accept at edge T sets out_valid=1 after edge T+2*SIZE; prod is valid and equals x*y mod 2^(2*SIZE) (exact, no overflow).
REQ-019 SHALL hold prod and out_valid stable in DONE while out_ready=0, for any number of cycles.
REQ-020 SHALL, in DONE with out_ready=1, return to IDLE on that edge; in_ready becomes 1 in the following cycle, so no accept coincides with a DONE handshake.
REQ-021 SHALL ignore in_valid, x and y outside IDLE, and ignore out_ready outside DONE.
REQ-022 SHALL produce correct results for x=0, y=0, and x=y=2^SIZE-1.

Reset
REQ-023 SHALL, while rst=0, force IDLE, in_ready=1, out_valid=0, prod=0, cnt=0, and all s_i, c_i, x_r and y_sr to 0, regardless of clock.
REQ-024 SHALL, on rst asserted mid-RUN or in DONE, discard the operation; the first accept after rst returns high starts a clean operation.

Configuration
REQ-025 SHALL, when SPM_SERIAL_OUT_EN is defined, add outputs p (1 bit, equal to the product bit registered in the current step) and p_vld (1 bit, high for exactly the 2*SIZE cycles following each RUN edge, with p valid in the same cycle), both reset to 0.
REQ-026 SHALL, when SPM_SERIAL_OUT_EN is undefined, have no p or p_vld ports, with all other behaviour identical.

Verification (SIZE=8)
REQ-027 SHALL cover: x=0xFF, y=0xFF accepted at edge T -> out_valid rises after edge T+16 with prod=0xFE01.
REQ-028 SHALL cover: x=0x03, y=0x05 -> prod=0x000F; and x=0x00, y=0xA5 -> prod=0x0000.
REQ-029 SHALL cover: out_ready held 0 for 10 cycles in DONE -> prod and out_valid stable; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-030 SHALL cover: back-to-back pairs (0x12,0x34) then (0x80,0x02) with in_valid constantly 1 -> prod 0x03A8 then 0x0100; second accept occurs one cycle after the first DONE handshake.
REQ-031 SHALL cover: rst pulsed low at cnt=5 of a RUN -> out_valid=0 and in_ready=1 immediately; next pair (0x0F,0x0F) -> prod=0x00E1.
REQ-032 SHALL cover, with SPM_SERIAL_OUT_EN defined: x=0x03, y=0x05 -> p sequence LSB first 1,1,1,1,0,...,0 over 16 cycles with p_vld=1.
